axis_source: RTL

AXI-Stream transmitter: accepts words from a local producer over a simple valid/ready port and drives them onto an AXI-Stream master interface, framing every PKT_LEN beats with `m_axis_tlast`. It pairs with `axis_sink` as the upstream end of the `axis_example` stream. Internal buffering is a small synchronous FIFO followed by a registered output stage. Output backpressure (`m_axis_tready` low) never corrupts or drops data.

---
 rtl/axis_pkg.sv | 21 ++
 rtl/axis_source_if.sv | 14 +
 rtl/axis_fifo.sv | 58 +++++
 rtl/axis_source.sv | 92 +++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared AXI-Stream definitions used by axis_source and axis_sink.
// No logic; constants and an elaboration-time helper only.
// No backpressure involvement.
package axis_pkg;

    localparam int AXIS_WIDTH = 32;

    // Ceiling log2 for sizing pointers and counters; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/axis_source_if.sv
// AXI-Stream bundle: master drives valid/data/last, slave drives ready.
// No latency; pure wiring.
// Backpressure carried by tready from slave to master.
interface axis_source_if #(
    parameter int AXIS_WIDTH = axis_pkg::AXIS_WIDTH
);
    logic                  tvalid;
    logic                  tready;
    logic [AXIS_WIDTH-1:0] tdata;
    logic                  tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_fifo.sv
// Synchronous FIFO with occupancy counter; full/empty come from the counter.
// Head word visible on rd_data combinationally; write-to-readable is 1 cycle.
// Writes while full and reads while empty are ignored.
module axis_fifo
    import axis_pkg::*;
#(
    parameter int AXIS_WIDTH = axis_pkg::AXIS_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [AXIS_WIDTH-1:0]       wr_data,
    input  logic                        rd_en,
    output logic [AXIS_WIDTH-1:0]       rd_data,
    output logic                        full,
    output logic                        empty,
    output logic [clog2(FIFO_DEPTH):0]  count
);
    localparam int PW = clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [AXIS_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  do_wr;
    logic                  do_rd;

    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage array: data needs no reset, it is only read when count says valid.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally; count tracks occupancy and holds on write+read.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PW'(1);
            if (do_rd) rd_ptr <= rd_ptr + PW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/axis_source.sv
// Local valid/ready producer port to AXI-Stream master, tlast every PKT_LEN beats.
// 2 cycles from accept to tvalid; 1 beat/cycle sustained.
// tready low fills FIFO + output register, then ready drops; nothing is lost.
module axis_source
    import axis_pkg::*;
#(
    parameter int AXIS_WIDTH = axis_pkg::AXIS_WIDTH,
    parameter int PKT_LEN    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid,
    input  logic [AXIS_WIDTH-1:0] data_in,
    output logic                  ready,
    output logic                  idle,
    axis_source_if.master         m_axis
);
    localparam int CW = clog2(FIFO_DEPTH) + 1;
    localparam int BW = (clog2(PKT_LEN) >= 1) ? clog2(PKT_LEN) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

    logic                  wr;
    logic                  load;
    logic                  full;
    logic                  empty;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_next;
    logic [AXIS_WIDTH-1:0] head;
    logic [BW-1:0]         beat;
    logic                  tvalid_q;
    logic                  tlast_q;
    logic [AXIS_WIDTH-1:0] tdata_q;

    // ready is registered, so it already guarantees room; full is a second guard.
    assign wr         = valid && ready && !full && !reset;
    assign load       = !empty && (!tvalid_q || m_axis.tready);
    assign count_next = count + CW'(wr) - CW'(load);
    assign idle       = empty && !tvalid_q;

    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tlast  = tlast_q;

    axis_fifo #(
        .AXIS_WIDTH (AXIS_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr),
        .wr_data (data_in),
        .rd_en   (load),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    // Producer ready: accept next cycle only if the FIFO will still have room.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready <= 1'b0;
        end else begin
            ready <= (count_next < CW'(FIFO_DEPTH));
        end
    end

    // Output register: refill from FIFO head whenever empty or being consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
        end else if (load) begin
            tvalid_q <= 1'b1;
            tdata_q  <= head;
            tlast_q  <= (beat == LAST_BEAT);
        end else if (tvalid_q && m_axis.tready) begin
            tvalid_q <= 1'b0;
        end
    end

    // Beat position within the packet, advanced once per output load.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat <= '0;
        end else if (load) begin
            beat <= (beat == LAST_BEAT) ? '0 : beat + BW'(1);
        end
    end
endmodule
